// File: rtl/ram_req_adapter.sv
// rtl/ram_req_adapter.sv - core req/gnt/rvalid bus to single-port RAM strobes with buffered in-order responses

module ram_req_adapter #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_i,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic                    rvalid_o,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   input  logic                    rready_i,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int PTR_W    = $clog2(RESP_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int OCC_W    = CNT_W + 1;

   // Tag pipe: one slot per cycle of RAM read latency; the last slot is the
   // request whose RAM data is on ram_rdata_i this cycle.
   logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LATENCY-1:0] tag_we_q, tag_we_d;

   // Response FIFO state
   logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];
   logic [PTR_W-1:0]      wptr_q, wptr_d;
   logic [PTR_W-1:0]      rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;

   logic [CNT_W-1:0]      inflight;
   logic [OCC_W-1:0]      occ;
   logic                  credit_ok;
   logic                  grant;
   logic                  push;
   logic                  pop;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [DATA_WIDTH-1:0] push_data;

   // Count requests still travelling through the RAM latency pipe
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         inflight = inflight + CNT_W'(tag_vld_q[i]);
      end
   end

   // Credit check uses registered state only, so a pop frees its slot one
   // cycle later and the grant path never depends on rready_i.
   always_comb begin
      occ       = OCC_W'(inflight) + OCC_W'(count_q);
      credit_ok = (occ < OCC_W'(RESP_DEPTH));
      grant     = req_i & ~rst_i & credit_ok;
   end

   assign gnt_o       = grant;
   assign ram_en_o    = grant;
   assign ram_we_o    = grant & we_i;
   assign ram_be_o    = be_i & {BE_WIDTH{we_i & ~rst_i}};
   assign ram_addr_o  = addr_i;
   assign ram_wdata_o = wdata_i;

   // Shift a {valid, we} tag per grant down the latency pipe
   always_comb begin
      tag_vld_d    = '0;
      tag_we_d     = '0;
      tag_vld_d[0] = grant;
      tag_we_d[0]  = grant & we_i;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_we_d[i]  = tag_we_q[i-1];
      end
   end

   // Tag pipe register; reset drops every request still in flight
   always_ff @(posedge clk) begin
      if (rst_i) begin
         tag_vld_q <= '0;
         tag_we_q  <= '0;
      end else begin
         tag_vld_q <= tag_vld_d;
         tag_we_q  <= tag_we_d;
      end
   end

   // Capture at the pipe head: writes answer with zero, reads with RAM data
   always_comb begin
      push       = tag_vld_q[RD_LATENCY-1];
      push_data  = tag_we_q[RD_LATENCY-1] ? '0 : ram_rdata_i;
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CNT_W'(RESP_DEPTH));
      pop        = ~fifo_empty & ~rst_i & rready_i;
   end

   assign rvalid_o = ~fifo_empty & ~rst_i;
   assign rdata_o  = rvalid_o ? fifo_q[rptr_q] : '0;

   // FIFO pointer and occupancy next-state; pointers wrap naturally
   always_comb begin
      wptr_d  = wptr_q + PTR_W'(push);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // FIFO control registers
   always_ff @(posedge clk) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // FIFO storage; contents are meaningless once the pointers are cleared
   always_ff @(posedge clk) begin
      if (!rst_i && push && !fifo_full) begin
         fifo_q[wptr_q] <= push_data;
      end
   end

   // The credit rule must keep a push from ever landing on a full FIFO
   a_no_overflow: assert property (@(posedge clk) disable iff (rst_i) push |-> !fifo_full);

endmodule
